// File: rtl/alu_result_buffer.sv
//------------------------------------------------------------------------------
// Module      : alu_result_buffer
// Description : Circular result-token FIFO between the integer datapath and a
//               downstream consumer, with skid nack, drain FSM and sticky
//               overflow. Define ALU_RESULT_BUFFER_STAT_EN to add O_Count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// FTk_t packing : {v, a, c, r, i, d[WIDTH_DATA-1:0]}  (v is the MSB)
// BTk_t packing : {n, b}                              (n is the MSB)
`default_nettype none

module alu_result_buffer #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH      = 4,
    parameter int SKID       = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Active,
    input  logic [WIDTH_DATA+4:0] I_FTk,
    output logic [1:0]            O_BTk,
    output logic [WIDTH_DATA+4:0] O_FTk,
    input  logic [1:0]            I_BTk,
    output logic                  O_Busy,
`ifdef ALU_RESULT_BUFFER_STAT_EN
    output logic                  O_Overflow,
    output logic [15:0]           O_Count
`else
    output logic                  O_Overflow
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TOK_W = WIDTH_DATA + 5;
    localparam int c_V_BIT = WIDTH_DATA + 4;

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_SKID_CNT  = c_CNT_W'(SKID);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic                 w_acceptEn;

    logic [c_TOK_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_countNext;
    logic                 r_overflow;

    logic                 w_tokValid;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_nack;
    logic                 w_unusedBtk;

    assign w_tokValid  = I_FTk[c_V_BIT];
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign w_empty     = (r_count == c_CNT_ZERO);
    assign w_unusedBtk = I_BTk[0];

    // A full buffer drops the token even if the head pops in the same cycle.
    assign w_push = w_tokValid & w_acceptEn & ~w_full;
    assign w_drop = w_tokValid & w_acceptEn &  w_full;
    assign w_pop  = ~w_empty & ~I_BTk[1];

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + c_CNT_ONE;
            2'b01:   w_countNext = r_count - c_CNT_ONE;
            default: w_countNext = r_count;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM: next-state decode
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (I_Active) begin
                    w_nextState = c_RUN;
                end
            end
            c_RUN: begin
                if (!I_Active) begin
                    w_nextState = w_empty ? c_IDLE : c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_countNext == c_CNT_ZERO) begin
                    w_nextState = c_IDLE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_acceptEn = 1'b0;
        O_Busy     = 1'b0;
        case (r_state)
            c_RUN: begin
                w_acceptEn = 1'b1;
                O_Busy     = 1'b1;
            end
            c_DRAIN: begin
                O_Busy     = 1'b1;
            end
            default: begin
                w_acceptEn = 1'b0;
                O_Busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= I_FTk;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            r_count <= w_countNext;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Nack depends on registered occupancy only, giving upstream SKID cycles of slack.
    assign w_nack     = ((c_DEPTH_CNT - r_count) <= c_SKID_CNT);
    assign O_BTk      = {w_nack, 1'b0};
    assign O_FTk      = w_pop ? {1'b1, r_mem[r_rdPtr][c_V_BIT-1:0]} : '0;
    assign O_Overflow = r_overflow;

`ifdef ALU_RESULT_BUFFER_STAT_EN
    logic [15:0] r_popCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_popCount <= '0;
        end else if (w_pop && (r_popCount != 16'hFFFF)) begin
            r_popCount <= r_popCount + 16'd1;
        end
    end

    assign O_Count = r_popCount;
`endif

endmodule

`default_nettype wire

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 32: data width carried in FTk_t.d.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; power of two, >=4.
REQ-003 SHALL have parameter SKID, default 2: free-entry threshold for nack; 1 <= SKID < DEPTH.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port I_Active  input  1  enables acceptance of result tokens.
REQ-007 SHALL have port I_FTk  input  FTk_t  result token from the integer datapath O_Result.
REQ-008 SHALL have port O_BTk  output  BTk_t  backward token to the datapath I_BTk.
REQ-009 SHALL have port O_FTk  output  FTk_t  buffered token to the downstream consumer.
REQ-010 SHALL have port I_BTk  input  BTk_t  backward token from downstream; .n = nack.
REQ-011 SHALL have port O_Busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port O_Overflow  output  1  sticky flag: a token arrived while the buffer was full.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH FTk_t entries with read/write pointers that wrap modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-014 SHALL push I_FTk (all fields v,a,c,r,i,d unmodified) when I_FTk.v=1, FSM=RUN and count<DEPTH.
REQ-015 SHALL treat I_FTk.v=1 in RUN with count==DEPTH as overflow: token dropped, O_Overflow set, count unchanged, even if a pop occurs the same cycle.
REQ-016 SHALL drive O_BTk.n=1 when (DEPTH-count) <= SKID, decoded from registered count only; all other O_BTk fields '0.
REQ-017 SHALL drive O_FTk = head entry with .v=1 when count>0 and I_BTk.n=0; otherwise O_FTk='0.
REQ-018 SHALL pop the head entry in any cycle where O_FTk.v=1.
REQ-019 SHALL give push-to-output latency of exactly 1 cycle: a token pushed in cycle N appears on O_FTk no earlier than cycle N+1; there is no bypass path.
REQ-020 SHALL update count by +1 (push only), -1 (pop only) or 0 (both or neither) on simultaneous events.
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN: IDLE->RUN on I_Active=1; RUN->IDLE on I_Active=0 with count==0; RUN->DRAIN on I_Active=0 with count>0; DRAIN->IDLE when the next count is 0.
REQ-022 SHALL in DRAIN reject all pushes without setting O_Overflow, continue popping, and ignore I_Active until IDLE is reached.
REQ-023 SHALL in IDLE ignore I_FTk entirely.
REQ-024 SHALL clear O_Overflow only by reset.

Reset
REQ-025 SHALL on reset=1 at a clock edge set pointers=0, count=0, FSM=IDLE and O_Overflow=0, discarding buffered tokens, including mid-stream.
REQ-026 SHALL hold O_FTk='0, O_BTk='0 and O_Busy=0 in the cycle after reset and until new activity.

Configuration
REQ-027 SHALL, with macro ALU_RESULT_BUFFER_STAT_EN defined, add port O_Count (output, 16 bits): saturating count of popped tokens, reset to 0, held at 16'hFFFF.
REQ-028 SHALL, without ALU_RESULT_BUFFER_STAT_EN, omit O_Count and its counter entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, I_Active=1, push d=0x11, 0x22 and 0x33 on consecutive cycles with I_BTk.n=0 -> O_FTk.d = 0x11, 0x22, 0x33 on cycles 1-3 after the first push; count returns to 0.
REQ-030 SHALL cover: DEPTH=4, SKID=2, I_BTk.n=1, push 2 tokens -> O_BTk.n=1 after the second push; push 2 more -> count=4; push a 5th -> O_Overflow=1 and count stays 4.
REQ-031 SHALL cover: count=4 and pointer wrap (8 pushes/pops interleaved) -> output order equals input order 0x1..0x8.
REQ-032 SHALL cover: 3 tokens buffered, I_Active dropped -> FSM=DRAIN and O_Busy=1; a token arriving during drain is dropped with O_Overflow=0; IDLE reached the cycle after the 3rd pop.
REQ-033 SHALL cover: reset asserted with count=3 -> the next cycle shows O_FTk.v=0, O_BTk.n=0, O_Busy=0, and with ALU_RESULT_BUFFER_STAT_EN O_Count=0.
